// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, boot/interrupt vector loader and IF/ID register.
// Optional interrupt support is built only when FETCH_INT_EN is defined.
module fetch_stage #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned INT_VEC   = 2,
    parameter logic [15:0] NOP       = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                interrupt,
    output logic [15:0]         instruction_r,
    output logic [PC_WIDTH-1:0] pc_r,
    output logic                interrupt_signal_r,
    output logic                valid_r
);

    typedef logic [PC_WIDTH-1:0] pc_t;

`ifdef FETCH_INT_EN
    typedef enum logic [2:0] {
        BOOT_HI, BOOT_LO, RUN, INT_HI, INT_LO
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT_HI, BOOT_LO, RUN
    } state_t;
`endif

    localparam pc_t RESET_ADDR = pc_t'(RESET_VEC);
    localparam pc_t INT_ADDR   = pc_t'(INT_VEC);
    localparam pc_t ONE        = pc_t'(1);

    state_t      state_q, state_d;
    pc_t         pc_q, pc_d;
    logic [15:0] instruction_d;
    pc_t         pc_r_d;
    logic        valid_d;
    logic        int_sig_d;
    logic        int_pending;
    logic        pend_d;

    // Vector words are loaded high half first into a 32-bit view of the PC.
    logic [31:0] pc_wide;
    pc_t         pc_hi_load;
    pc_t         pc_lo_load;

    assign pc_wide    = 32'(pc_q);
    assign pc_hi_load = pc_t'({imem_data, pc_wide[15:0]});
    assign pc_lo_load = pc_t'({pc_wide[31:16], imem_data});

    // Address selection: vector words while loading, PC while running.
    always_comb begin
        imem_addr = pc_q;
        unique case (state_q)
            BOOT_HI: imem_addr = RESET_ADDR;
            BOOT_LO: imem_addr = RESET_ADDR + ONE;
`ifdef FETCH_INT_EN
            INT_HI:  imem_addr = INT_ADDR;
            INT_LO:  imem_addr = INT_ADDR + ONE;
`endif
            default: imem_addr = pc_q;
        endcase
    end

    // Next PC, FSM state, IF/ID contents and pending-interrupt flag.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_r;
        pc_r_d        = pc_r;
        valid_d       = valid_r;
        int_sig_d     = interrupt_signal_r;
        pend_d        = int_pending | interrupt;
        unique case (state_q)
            BOOT_HI: begin
                pc_d    = pc_hi_load;
                state_d = BOOT_LO;
            end
            BOOT_LO: begin
                pc_d    = pc_lo_load;
                state_d = RUN;
            end
`ifdef FETCH_INT_EN
            INT_HI: begin
                pc_d    = pc_hi_load;
                state_d = INT_LO;
            end
            INT_LO: begin
                pc_d    = pc_lo_load;
                state_d = RUN;
            end
`endif
            RUN: begin
                if (branch_taken) begin
                    pc_d          = branch_target;
                    instruction_d = NOP;
                    valid_d       = 1'b0;
                    int_sig_d     = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
`ifdef FETCH_INT_EN
                end else if (int_pending) begin
                    // Marker carries the return address; a pulse
                    // arriving now merges into this request.
                    instruction_d = NOP;
                    pc_r_d        = pc_q;
                    int_sig_d     = 1'b1;
                    valid_d       = 1'b0;
                    pend_d        = 1'b0;
                    state_d       = INT_HI;
`endif
                end else begin
                    instruction_d = imem_data;
                    pc_r_d        = pc_q + ONE;
                    int_sig_d     = 1'b0;
                    valid_d       = 1'b1;
                    pc_d          = pc_q + ONE;
                end
            end
            default: state_d = BOOT_HI;
        endcase
        if (state_q != RUN && !stall) begin
            instruction_d = NOP;
            valid_d       = 1'b0;
            int_sig_d     = 1'b0;
        end
    end

    // State, PC and IF/ID register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= BOOT_HI;
            pc_q          <= '0;
            instruction_r <= NOP;
            pc_r          <= '0;
            valid_r       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_r <= instruction_d;
            pc_r          <= pc_r_d;
            valid_r       <= valid_d;
        end
    end

`ifdef FETCH_INT_EN
    // Interrupt request latch and the marker bit of IF/ID.
    always_ff @(posedge clk) begin
        if (!reset) begin
            int_pending        <= 1'b0;
            interrupt_signal_r <= 1'b0;
        end else begin
            int_pending        <= pend_d;
            interrupt_signal_r <= int_sig_d;
        end
    end
`else
    // Without interrupt support the request input has no effect.
    logic unused_int;
    assign int_pending        = 1'b0;
    assign interrupt_signal_r = 1'b0;
    assign unused_int         = &{1'b0, pend_d, int_sig_d};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan plus random stimulus against a
// cycle-level reference model of the fetch stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        interrupt;
    logic [15:0] instruction_r;
    logic [31:0] pc_r;
    logic        interrupt_signal_r;
    logic        valid_r;

    logic [15:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FETCH_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[9:0]];

    fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .imem_addr          (imem_addr),
        .imem_data          (imem_data),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .interrupt          (interrupt),
        .instruction_r      (instruction_r),
        .pc_r               (pc_r),
        .interrupt_signal_r (interrupt_signal_r),
        .valid_r            (valid_r)
    );

    // Reference model: words_left counts vector words still to load.
    logic [31:0] m_pc;
    logic [31:0] m_base;
    int          m_left;
    bit          m_pend;
    logic [15:0] m_ins;
    logic [31:0] m_pcr;
    bit          m_int;
    bit          m_valid;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_addr();
        if (m_left == 2) return m_base;
        if (m_left == 1) return m_base + 32'd1;
        return m_pc;
    endfunction

    task automatic model_edge(input bit rst, input bit stl,
                              input bit br, input logic [31:0] tgt,
                              input bit irq);
        logic [31:0] a;
        logic [15:0] w;
        bit          pend_next;
        if (!rst) begin
            m_left = 2; m_base = 32'd0; m_pc = 32'd0;
            m_pend = 0; m_ins = 16'h0000; m_pcr = 32'd0;
            m_int = 0; m_valid = 0;
            return;
        end
        a = m_addr();
        w = mem[a[9:0]];
        pend_next = m_pend | (INT_EN & irq);
        if (m_left > 0) begin
            if (m_left == 2) m_pc = {w, m_pc[15:0]};
            else             m_pc = {m_pc[31:16], w};
            m_left--;
            if (!stl) begin
                m_ins = 16'h0000; m_valid = 0; m_int = 0;
            end
        end else if (br) begin
            m_pc = tgt;
            m_ins = 16'h0000; m_valid = 0; m_int = 0;
        end else if (stl) begin
            m_pc = m_pc;
        end else if (m_pend) begin
            m_ins = 16'h0000; m_pcr = m_pc;
            m_int = 1; m_valid = 0;
            pend_next = 0;
            m_left = 2; m_base = 32'd2;
        end else begin
            m_ins = w; m_pcr = m_pc + 32'd1;
            m_int = 0; m_valid = 1;
            m_pc = m_pc + 32'd1;
        end
        m_pend = pend_next;
    endtask

    task automatic step(input bit rst, input bit stl,
                        input bit br, input logic [31:0] tgt,
                        input bit irq);
        reset = rst; stall = stl; branch_taken = br;
        branch_target = tgt; interrupt = irq;
        model_edge(rst, stl, br, tgt, irq);
        @(posedge clk);
        #1;
        check("instruction_r", {16'h0, instruction_r}, {16'h0, m_ins});
        check("pc_r", pc_r, m_pcr);
        check("int_sig", {31'h0, interrupt_signal_r}, {31'h0, m_int});
        check("valid_r", {31'h0, valid_r}, {31'h0, m_valid});
        check("imem_addr", imem_addr, m_addr());
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0000; mem[1] = 16'h0010;
        mem[2] = 16'h0000; mem[3] = 16'h0100;
        mem[16'h10] = 16'hA123;
        reset = 0; stall = 0; branch_taken = 0;
        branch_target = 0; interrupt = 0;

        // reset values
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h55, 1);
        check("rst_instr", {16'h0, instruction_r}, 32'h0);
        check("rst_valid", {31'h0, valid_r}, 32'h0);
        check("rst_pc_r", pc_r, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // boot: RUN in the third cycle
        step(1, 0, 0, 0, 0);
        check("boot_lo_addr", imem_addr, 32'h1);
        step(1, 0, 0, 0, 0);
        check("boot_addr", imem_addr, 32'h10);
        step(1, 0, 0, 0, 0);
        check("first_instr", {16'h0, instruction_r}, 32'hA123);
        check("first_pc_r", pc_r, 32'h11);
        check("first_valid", {31'h0, valid_r}, 32'h1);
        step(1, 0, 0, 0, 0);

        // stall holds PC and IF/ID
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("stall_addr", imem_addr, 32'h12);
        check("stall_pc_r", pc_r, 32'h12);
        step(1, 0, 0, 0, 0);
        check("resume_pc_r", pc_r, 32'h13);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // branch overrides stall, one bubble
        step(1, 1, 1, 32'h40, 0);
        check("br_valid", {31'h0, valid_r}, 32'h0);
        check("br_addr", imem_addr, 32'h40);
        step(1, 0, 0, 0, 0);
        check("br_instr", {16'h0, instruction_r},
              {16'h0, mem[16'h40]});
        check("br_pc_r", pc_r, 32'h41);

        // interrupt while stalled at 0x14
        step(1, 0, 1, 32'h14, 0);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
`ifdef FETCH_INT_EN
        check("irq_marker", {31'h0, interrupt_signal_r}, 32'h1);
        check("irq_pc_r", pc_r, 32'h14);
        check("irq_vec_addr", imem_addr, 32'h2);
`endif
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
`ifdef FETCH_INT_EN
        check("handler_addr", imem_addr, 32'h100);
`endif
        step(1, 0, 0, 0, 0);

        // branch and interrupt together
        step(1, 0, 1, 32'h40, 1);
        check("combo_bubble", {31'h0, valid_r}, 32'h0);
        step(1, 0, 0, 0, 0);
`ifdef FETCH_INT_EN
        check("combo_marker", {31'h0, interrupt_signal_r}, 32'h1);
        check("combo_pc_r", pc_r, 32'h40);
`endif
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // reset during the second vector cycle loses the request
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("rst2_int", {31'h0, interrupt_signal_r}, 32'h0);
        check("rst2_addr", imem_addr, 32'h0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            check("no_marker", {31'h0, interrupt_signal_r}, 32'h0);
        end

        // PC wraps from all-ones to zero
        step(1, 0, 1, 32'hFFFF_FFFF, 0);
        step(1, 0, 0, 0, 0);
        check("wrap_pc_r", pc_r, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit          r, s, b, q;
            logic [31:0] t;
            r = ($urandom_range(0, 299) != 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            q = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFF;
            else t = 32'($urandom_range(0, 1023));
            step(r, s, b, t, q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
